// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg : shared operation encoding and width helpers for param_stack
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stack_pkg;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_FLUSH   = 3'd4,
        OP_PUSH_UF = 3'd5,
        OP_OVF     = 3'd6,
        OP_UDF     = 3'd7
    } stack_op_e;

    // Count must represent 0..DEPTH inclusive; index only 0..DEPTH-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/param_stack_if.sv
// ---------------------------------------------------------------------------
// param_stack_if : request/status bundle between a stack user and param_stack
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface param_stack_if
    import stack_pkg::*;
#(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int IDX_W = idx_width(DEPTH);

    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              flush;
    logic              err_clr;
    logic [IDX_W-1:0]  peek_idx;
    logic [DATA_W-1:0] top_data;
    logic [DATA_W-1:0] peek_data;
    logic              peek_valid;
    logic [CNT_W-1:0]  count;
    logic              stack_empty;
    logic              stack_full;
    logic              overflow;
    logic              underflow;
    logic [CNT_W-1:0]  high_water;

    modport master (
        output push, push_data, pop, flush, err_clr, peek_idx,
        input  top_data, peek_data, peek_valid, count, stack_empty,
               stack_full, overflow, underflow, high_water
    );

    modport slave (
        input  push, push_data, pop, flush, err_clr, peek_idx,
        output top_data, peek_data, peek_valid, count, stack_empty,
               stack_full, overflow, underflow, high_water
    );

endinterface

`default_nettype wire

// File: rtl/stack_regfile.sv
// ---------------------------------------------------------------------------
// stack_regfile : DEPTH x DATA_W entry array, one write port, two read ports
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stack_regfile #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_we,
    input  wire logic [IDX_W-1:0]  i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [IDX_W-1:0]  i_top_addr,
    input  wire logic [IDX_W-1:0]  i_peek_addr,
    output logic      [DATA_W-1:0] o_top_rdata,
    output logic      [DATA_W-1:0] o_peek_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_mem[gi] <= '0;
            end else if (i_we && (i_waddr == IDX_W'(gi))) begin
                r_mem[gi] <= i_wdata;
            end
        end
    end

    // Addresses are only meaningful when the caller has qualified them.
    assign o_top_rdata  = r_mem[i_top_addr];
    assign o_peek_rdata = r_mem[i_peek_addr];

endmodule

`default_nettype wire

// File: rtl/param_stack.sv
// ---------------------------------------------------------------------------
// param_stack : parametrised LIFO with replace, peek, flush, sticky errors
//               and high-water tracking
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module param_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 16
) (
    input  wire logic    clk,
    input  wire logic    reset,
    param_stack_if.slave bus
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int IDX_W = idx_width(DEPTH);

    stack_op_e         w_op;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_next_count;
    logic [CNT_W-1:0]  r_high_water;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_ovf_evt;
    logic              w_udf_evt;
    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_peek_addr;
    logic [DATA_W-1:0] w_rd_top;
    logic [DATA_W-1:0] w_rd_peek;
    logic              w_empty;
    logic              w_full;
    logic              w_peek_valid;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNT_W'(DEPTH));
    // Modulo IDX_W wrap maps count==DEPTH onto DEPTH-1 for power-of-two depths.
    assign w_top_idx    = r_count[IDX_W-1:0] - IDX_W'(1);
    assign w_peek_addr  = w_top_idx - bus.peek_idx;
    assign w_peek_valid = (CNT_W'(bus.peek_idx) < r_count);

    always_comb begin
        w_op = OP_NONE;
        if (bus.flush) begin
            w_op = OP_FLUSH;
        end else if (bus.push && bus.pop) begin
            w_op = w_empty ? OP_PUSH_UF : OP_REPLACE;
        end else if (bus.push) begin
            w_op = w_full ? OP_OVF : OP_PUSH;
        end else if (bus.pop) begin
            w_op = w_empty ? OP_UDF : OP_POP;
        end
    end

    always_comb begin
        w_next_count = r_count;
        w_we         = 1'b0;
        w_waddr      = w_top_idx;
        w_ovf_evt    = 1'b0;
        w_udf_evt    = 1'b0;
        case (w_op)
            OP_FLUSH:   w_next_count = '0;
            OP_REPLACE: w_we = 1'b1;
            OP_PUSH_UF: begin
                w_we         = 1'b1;
                w_waddr      = '0;
                w_next_count = CNT_W'(1);
                w_udf_evt    = 1'b1;
            end
            OP_PUSH: begin
                w_we         = 1'b1;
                w_waddr      = r_count[IDX_W-1:0];
                w_next_count = r_count + CNT_W'(1);
            end
            OP_POP:     w_next_count = r_count - CNT_W'(1);
            OP_OVF:     w_ovf_evt = 1'b1;
            OP_UDF:     w_udf_evt = 1'b1;
            default:    w_next_count = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_high_water <= '0;
        end else begin
            r_count <= w_next_count;
            // A new error in the clearing cycle must survive the clear.
            if (bus.err_clr) begin
                r_overflow   <= w_ovf_evt;
                r_underflow  <= w_udf_evt;
                r_high_water <= w_next_count;
            end else begin
                r_overflow  <= r_overflow  | w_ovf_evt;
                r_underflow <= r_underflow | w_udf_evt;
                if (w_next_count > r_high_water) begin
                    r_high_water <= w_next_count;
                end
            end
        end
    end

    stack_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .i_we         (w_we),
        .i_waddr      (w_waddr),
        .i_wdata      (bus.push_data),
        .i_top_addr   (w_top_idx),
        .i_peek_addr  (w_peek_addr),
        .o_top_rdata  (w_rd_top),
        .o_peek_rdata (w_rd_peek)
    );

    assign bus.top_data    = w_empty ? '0 : w_rd_top;
    assign bus.peek_data   = w_peek_valid ? w_rd_peek : '0;
    assign bus.peek_valid  = w_peek_valid;
    assign bus.count       = r_count;
    assign bus.stack_empty = w_empty;
    assign bus.stack_full  = w_full;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.high_water  = r_high_water;

endmodule

`default_nettype wire

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO for the CPU call/return and operand path; successor of the fixed 19-bit, 16-entry stack.
- Adds the following over the fixed stack:
  - configurable width and depth, with all DEPTH entries usable;
  - simultaneous push+pop as a replace-top operation;
  - a second read port that peeks at an offset from the top;
  - synchronous flush;
  - sticky overflow/underflow error flags;
  - occupancy count and high-water mark.

Parameters:
- DATA_W, 19, width of each entry.
- DEPTH, 16, number of entries; must be at least 2.
- CNT_W, $clog2(DEPTH+1), width of the count and watermark outputs (derived, not overridden).
- IDX_W, $clog2(DEPTH), width of the peek offset (derived).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- push  in  1  push request
- push_data  in  DATA_W  data to push
- pop  in  1  pop request
- flush  in  1  synchronous empty request
- err_clr  in  1  clears the sticky flags and the watermark
- peek_idx  in  IDX_W  offset from top (0 = top)
- top_data  out  DATA_W  current top entry, combinational
- peek_data  out  DATA_W  entry at top minus peek_idx, combinational
- peek_valid  out  1  peek_idx < count
- count  out  CNT_W  occupancy, 0..DEPTH
- stack_empty  out  1  count == 0
- stack_full  out  1  count == DEPTH
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty
- high_water  out  CNT_W  maximum count since reset or err_clr

Behaviour:
- Reset (asynchronous, active-high):
  - count = 0, overflow = 0, underflow = 0, high_water = 0, all memory entries = 0.
  - Reset asserted mid-sequence discards any in-flight operation immediately.
- Storage: mem[0] is the bottom entry; the top entry is mem[count-1]. All state updates occur on the rising clk edge.
- Read ports (zero latency, combinational):
  - top_data = mem[count-1] if count > 0, else 0.
  - peek_data = mem[count-1-peek_idx] if peek_idx < count, else 0.
  - Both reflect the state before the edge, never the same-cycle push.
- Operation priority, evaluated each cycle:
  1. flush: count <= 0. Memory contents are untouched. push/pop in the same cycle are ignored and raise no error.
  2. push & pop, count > 0: replace. mem[count-1] <= push_data; count unchanged. No error, including when full.
  3. push & pop, count == 0: the push executes (mem[0] <= push_data, count <= 1) and underflow is set.
  4. push only, not full: mem[count] <= push_data; count <= count+1.
  5. push only, full: no state change; overflow set.
  6. pop only, not empty: count <= count-1. Entry contents are retained.
  7. pop only, empty: no state change; underflow set.
- Sticky flags:
  - Once set, a flag holds until err_clr or reset.
  - If err_clr coincides with a new error, set wins: the flag reads 1 after the edge.
- high_water:
  - Each cycle, if next_count > high_water, then high_water <= next_count.
  - err_clr loads high_water <= next_count, not 0, so it tracks the current occupancy.
- Arithmetic: count arithmetic is CNT_W wide and never wraps, because the guards above prevent it. Index arithmetic is IDX_W wide.
- Status: stack_empty and stack_full are combinational decodes of count.

Decomposition:
- stack_pkg:
  - stack_op_e enum: OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_FLUSH, OP_PUSH_UF, OP_OVF, OP_UDF.
  - A function deriving CNT_W and IDX_W from DEPTH.
- Sub-module stack_regfile: a DEPTH x DATA_W register array with async reset, one write port, and two combinational read ports (top, peek).
- The top level holds the op decode, the count register, the flags and the watermark.

Test Plan (DATA_W=19, DEPTH=16):
- Reset, then push 0x00001..0x00010 (16 pushes) → count=16, stack_full=1, top_data=0x00010, high_water=16; a 17th push of 0x7FFFF → count stays 16, top_data stays 0x00010, overflow=1.
- From 3 entries (0xA, 0xB, 0xC), drive push=1, pop=1, push_data=0x12345 → count=3, top_data=0x12345; peek_idx=1 → peek_data=0xB, peek_valid=1; peek_idx=3 → peek_data=0, peek_valid=0.
- From empty, pop → underflow=1, count=0, top_data=0; then push & pop with 0x55 → count=1, top_data=0x55, underflow stays 1.
- From 5 entries, assert flush with push=1 → count=0, stack_empty=1, no flag change; a following push of 0x9 → top_data=0x9, count=1.
- With overflow=1 and high_water=16 at count=4, assert err_clr → overflow=0, high_water=4; err_clr together with a full-stack push → overflow remains 1.
- Assert reset asynchronously mid-cycle at count=7 → count=0, all flags 0, top_data=0 without waiting for a clock edge.
